fifo_slow_blk_mc: RTL

Multi-channel circular FIFO in the slow clock domain. It buffers segment words for the buffer/stage-output path. It holds NUM_CH independent queues of DEPTH words each and manages their pointers and occupancy internally, so callers no longer supply raw addresses. It adds per-channel full, empty and almost-full flags, a registered read with a valid strobe, per-channel flush, and sticky overflow/underflow error bits.

---
 rtl/fifo_slow_blk_mc.sv | 91 +++++++++
 1 files changed

// File: rtl/fifo_slow_blk_mc.sv
// fifo_slow_blk_mc: multi-channel circular FIFO with per-channel flags, flush, registered read and sticky errors
module fifo_slow_blk_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int BITS_ADDR  = 3,
  parameter int NUM_CH     = 4,
  parameter int BITS_CH    = 2,
  parameter int AF_LEVEL   = DEPTH - 2
) (
  input  logic                            clk_slow,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [BITS_CH-1:0]              wr_ch,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            rd_en,
  input  logic [BITS_CH-1:0]              rd_ch,
  input  logic [NUM_CH-1:0]               flush,
  input  logic                            err_clr,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            rd_valid,
  output logic [BITS_CH-1:0]              rd_ch_out,
  output logic [NUM_CH-1:0]               full,
  output logic [NUM_CH-1:0]               empty,
  output logic [NUM_CH-1:0]               almost_full,
  output logic [NUM_CH*(BITS_ADDR+1)-1:0] count,
  output logic [NUM_CH-1:0]               overflow,
  output logic [NUM_CH-1:0]               underflow
);
  localparam int CW = BITS_ADDR + 1;
  logic [DATA_WIDTH-1:0] mem [NUM_CH*DEPTH];
  logic [BITS_ADDR-1:0]  wr_ptr [NUM_CH];
  logic [BITS_ADDR-1:0]  rd_ptr [NUM_CH];
  logic [CW-1:0]         cnt [NUM_CH];
  logic [NUM_CH-1:0]     wr_sel, rd_sel;
  logic                  wr_ok, rd_ok, wr_acc, rd_acc, wr_err, rd_err;
  always_comb begin
    count = '0;
    full = '0;
    empty = '0;
    almost_full = '0;
    wr_sel = '0;
    rd_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      count[c*CW +: CW] = cnt[c];
      full[c] = cnt[c] == CW'(DEPTH);
      empty[c] = cnt[c] == '0;
      almost_full[c] = cnt[c] >= CW'(AF_LEVEL);
      wr_sel[c] = wr_ch == BITS_CH'(c);
      rd_sel[c] = rd_ch == BITS_CH'(c);
    end
  end
  // Out-of-range channels and flushed channels are silently ignored (no error bit)
  assign wr_ok  = !rst && int'(wr_ch) < NUM_CH && !flush[wr_ch];
  assign rd_ok  = !rst && int'(rd_ch) < NUM_CH && !flush[rd_ch];
  assign rd_acc = rd_en && rd_ok && !empty[rd_ch];
  assign rd_err = rd_en && rd_ok && empty[rd_ch];
  // A full channel still takes a write when the same edge pops a word from it
  assign wr_acc = wr_en && wr_ok && (!full[wr_ch] || (rd_acc && rd_ch == wr_ch));
  assign wr_err = wr_en && wr_ok && !wr_acc;
  always_ff @(posedge clk_slow)
    if (wr_acc) mem[{wr_ch, wr_ptr[wr_ch]}] <= data_in;
  always_ff @(posedge clk_slow) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      rd_ch_out <= '0;
      overflow <= '0;
      underflow <= '0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        data_out <= mem[{rd_ch, rd_ptr[rd_ch]}];
        rd_ch_out <= rd_ch;
      end
      // A new error beats err_clr in the same cycle
      overflow <= (err_clr ? '0 : overflow) | (wr_err ? wr_sel : '0);
      underflow <= (err_clr ? '0 : underflow) | (rd_err ? rd_sel : '0);
    end
  end
  always_ff @(posedge clk_slow)
    for (int c = 0; c < NUM_CH; c++)
      if (rst || flush[c]) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c] <= '0;
      end else begin
        if (wr_acc && wr_sel[c]) wr_ptr[c] <= wr_ptr[c] + BITS_ADDR'(1);
        if (rd_acc && rd_sel[c]) rd_ptr[c] <= rd_ptr[c] + BITS_ADDR'(1);
        cnt[c] <= cnt[c] + CW'(wr_acc && wr_sel[c]) - CW'(rd_acc && rd_sel[c]);
      end
endmodule
